// File: rtl/dac_sample_feeder.sv
`default_nettype none
// =============================================================================
// Module   : dac_sample_feeder
// Brief    : Buffers AGC samples and feeds offset-binary codes to a framed DAC;
//            define DAC_FEEDER_UNDERRUN_CNT_EN to add the underrun_cnt output.
// Revision : 1.0
// =============================================================================
module dac_sample_feeder #(
    parameter int         FRAME_LEN  = 128,
    parameter logic [5:0] CONF       = 6'b110010,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic [11:0] dac_data,
    output logic [5:0]  dac_conf,
    output logic        dac_set,
    output logic        dac_enable,
    output logic        underrun
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]  underrun_cnt
`endif
);

    localparam int             CW          = $clog2(FRAME_LEN);
    localparam int             AW          = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  FRAME_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]  FRAME_UPD   = CW'(FRAME_LEN - 3);
    localparam logic [AW:0]    DEPTH_W     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [11:0]    MID_CODE    = 12'h800;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  frame_cnt;
    logic [11:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic [16:0]    sum;
    logic [11:0]    code;
    logic           unused_sum_lsbs;
    logic           full;
    logic           empty;
    logic           push;
    logic           update;
    logic           pop;

    // Rounding offset of half an output LSB, with positive overflow clamped.
    assign sum             = {s_data[15], s_data} + 17'd8;
    assign code            = (!sum[16] && sum[15]) ? 12'hFFF : {~sum[15], sum[14:4]};
    assign unused_sum_lsbs = ^sum[3:0];

    assign full     = (count == DEPTH_W);
    assign empty    = (count == '0);
    assign s_ready  = !full && (state != IDLE);
    assign push     = s_valid && s_ready;
    assign update   = (state == STREAM) && (frame_cnt == FRAME_UPD);
    assign pop      = update && !empty;
    assign dac_conf = CONF;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dac_data   <= MID_CODE;
            dac_set    <= 1'b0;
            dac_enable <= 1'b0;
            underrun   <= 1'b0;
        end else if (!run) begin
            // Dropping run parks the DAC at mid-scale and discards queued samples.
            state      <= IDLE;
            frame_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dac_data   <= MID_CODE;
            dac_set    <= 1'b0;
            dac_enable <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= update && empty;

            if (state == IDLE) begin
                state      <= CONFIG;
                dac_set    <= 1'b1;
                dac_enable <= 1'b1;
            end else begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                if ((state == CONFIG) && (frame_cnt == FRAME_LAST)) begin
                    state   <= STREAM;
                    dac_set <= 1'b0;
                end
            end

            if (pop) begin
                dac_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (!run) begin
            underrun_cnt <= '0;
        end else if (update && empty && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// Testbench for dac_sample_feeder: conversion table fed through a scoreboard,
// plus startup, backpressure, underrun, stop and async-reset sequences.
module tb_dac_sample_feeder;

    localparam int FL    = 128;
    localparam int DEPTH = 4;
    localparam int NVEC  = 9;

    typedef struct packed {
        logic [15:0] din;
        logic [11:0] code;
    } vec_t;

    vec_t tbl [NVEC];

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [11:0] dac_data;
    logic [5:0]  dac_conf;
    logic        dac_set;
    logic        dac_enable;
    logic        underrun;
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    always #5 clk = ~clk;

    dac_sample_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .dac_data   (dac_data),
        .dac_conf   (dac_conf),
        .dac_set    (dac_set),
        .dac_enable (dac_enable),
        .underrun   (underrun)
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    logic [11:0] sb [$];
    logic [11:0] exp_code;
    logic        exp_under;
    int          ph;
    int          ucnt;
    int          idx;
    int          lim;
    int          cyc;
    int          nvec;
    int          nerr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        if (idx < lim) begin
            s_valid = 1'b1;
            s_data  = tbl[idx % NVEC].din;
        end else begin
            s_valid = 1'b0;
            s_data  = 16'h0000;
        end
    endtask

    task automatic check_outputs();
        chk("dac_data",   32'(dac_data),   32'(exp_code));
        chk("underrun",   32'(underrun),   32'(exp_under));
        chk("dac_enable", 32'(dac_enable), 32'(ph >= 0));
        chk("dac_set",    32'(dac_set),    32'((ph >= 0) && (ph < FL)));
        chk("s_ready",    32'(s_ready),    32'((ph >= 0) && (sb.size() < DEPTH)));
        chk("dac_conf",   32'(dac_conf),   32'(6'b110010));
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'(ucnt));
`endif
    endtask

    // One clock: the reference model advances on what was presented before the edge.
    task automatic tick();
        logic acc;
        logic run_s;
        logic rst_s;
        bit   upd;
        acc   = s_valid & s_ready;
        run_s = run;
        rst_s = rst;
        upd   = (ph >= FL) && (((ph - FL) % FL) == FL - 3);
        @(posedge clk);
        #1;
        cyc++;
        exp_under = 1'b0;
        if (rst_s || !run_s) begin
            ph       = -1;
            exp_code = 12'h800;
            ucnt     = 0;
            sb.delete();
        end else begin
            if (upd) begin
                if (sb.size() > 0) begin
                    exp_code = sb.pop_front();
                end else begin
                    exp_under = 1'b1;
                    if (ucnt < 255) ucnt++;
                end
            end
            if (acc === 1'b1) begin
                sb.push_back(tbl[idx % NVEC].code);
                idx++;
            end
            ph++;
        end
        check_outputs();
        drive();
    endtask

    initial begin
        int nset;
        int nund;

        tbl[0] = '{din: 16'h1234, code: 12'h923};
        tbl[1] = '{din: 16'h0000, code: 12'h800};
        tbl[2] = '{din: 16'h7FFF, code: 12'hFFF};
        tbl[3] = '{din: 16'h8000, code: 12'h000};
        tbl[4] = '{din: 16'hFFF7, code: 12'h7FF};
        tbl[5] = '{din: 16'h7FF7, code: 12'hFFF};
        tbl[6] = '{din: 16'h7FF8, code: 12'hFFF};
        tbl[7] = '{din: 16'hFFF8, code: 12'h800};
        tbl[8] = '{din: 16'hC000, code: 12'h400};

        rst = 1'b1; run = 1'b0; s_valid = 1'b0; s_data = 16'h0000;
        idx = 0; lim = 0; ph = -1; exp_code = 12'h800; exp_under = 1'b0;
        ucnt = 0; cyc = 0; nvec = 0; nerr = 0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Startup with s_valid held: the FIFO fills during CONFIG.
        run = 1'b1;
        lim = NVEC;
        drive();
        nset = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dac_set) nset++;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 400 && ph < FL + FL - 3; i++) begin
            tick();
            if (dac_set) nset++;
        end
        chk("config_len", 32'(nset), 32'(FL));
        chk("pre_pop_dac", 32'(dac_data), 32'h800);
        tick();
        chk("first_pop_dac", 32'(dac_data), 32'h923);
        chk("bp_release", 32'(s_ready), 32'd1);

        // Drain the rest of the conversion table.
        for (int i = 0; i < 3000 && !(idx == NVEC && sb.size() == 0); i++) tick();
        chk("drain_done", 32'((idx == NVEC) && (sb.size() == 0)), 32'd1);

        nund = 0;
        for (int i = 0; i < 3 * FL; i++) begin
            tick();
            if (underrun) nund++;
        end
        chk("underrun_pulses", 32'(nund), 32'd3);
        chk("underrun_hold", 32'(dac_data), 32'h400);
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        chk("underrun_cnt_3", 32'(underrun_cnt), 32'd3);
`endif

        // Stop with two samples queued, then restart: the flushed FIFO must underrun.
        lim = idx + 2;
        drive();
        tick();
        tick();
        tick();
        chk("stop_queued", 32'(sb.size()), 32'd2);
        run = 1'b0;
        tick();
        chk("stop_dac", 32'(dac_data), 32'h800);
        chk("stop_enable", 32'(dac_enable), 32'd0);
        chk("stop_ready", 32'(s_ready), 32'd0);
        run = 1'b1;
        for (int i = 0; i < 400 && ph < FL + FL - 2; i++) tick();
        chk("flush_underrun", 32'(underrun), 32'd1);
        chk("flush_dac", 32'(dac_data), 32'h800);

        // Asynchronous reset mid-STREAM, observed before the next clock edge.
        lim = idx + 2;
        drive();
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_dac", 32'(dac_data), 32'h800);
        chk("rst_async_enable", 32'(dac_enable), 32'd0);
        chk("rst_async_ready", 32'(s_ready), 32'd0);
        chk("rst_async_set", 32'(dac_set), 32'd0);
        tick();
        rst = 1'b0;
        run = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 128, meaning clocks per DAC frame (downstream serializer counter period); legal 32..128.
REQ-002 The block SHALL have parameter CONF, default 6'b110010, meaning the DAC configuration word forwarded downstream.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (power of two, 2..16).
REQ-004 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port run, input, 1: level request to stream samples to the DAC.
REQ-007 Port s_valid, input, 1: upstream sample valid.
REQ-008 Port s_data, input, 16: signed two's-complement audio sample from the AGC stage.
REQ-009 Port s_ready, output, 1: sample accepted on a clk edge when s_valid and s_ready are both high.
REQ-010 Port dac_data, output, 12: offset-binary DAC code.
REQ-011 Port dac_conf, output, 6: equals CONF at all times.
REQ-012 Port dac_set, output, 1: request control-register write downstream.
REQ-013 Port dac_enable, output, 1: frame-counter enable for the downstream serializer.
REQ-014 Port underrun, output, 1: one-cycle pulse when a frame update finds the FIFO empty.

Function
REQ-015 States SHALL be IDLE, CONFIG, STREAM; IDLE->CONFIG when run=1; CONFIG->STREAM at the first frame wrap; any state->IDLE on the cycle after run=0.
REQ-016 dac_enable SHALL be 1 in CONFIG and STREAM, 0 in IDLE.
REQ-017 frame_cnt SHALL be 0 while dac_enable=0, increment each cycle while dac_enable=1, wrap FRAME_LEN-1 -> 0, and thereby stay aligned with the downstream counter.
REQ-018 dac_set SHALL be 1 throughout CONFIG and 0 otherwise.
REQ-019 Conversion SHALL be: r = s_data + 8 (17-bit signed); if r > 32767 then code = 12'hFFF, else code = {~r[15], r[14:4]}.
REQ-020 Conversion SHALL be registered at FIFO write (one-cycle accept-to-storage latency).
REQ-021 s_ready SHALL be 1 exactly when the FIFO is not full and state is not IDLE.
REQ-022 Update point SHALL be the cycle with frame_cnt == FRAME_LEN-3 in STREAM.
REQ-023 At the update point with FIFO non-empty, the head SHALL be popped and appear on dac_data on the next cycle; dac_data SHALL otherwise be stable.
REQ-024 At the update point with FIFO empty, dac_data SHALL hold its value and underrun SHALL pulse for one cycle.
REQ-025 A push and a pop on the same cycle SHALL both take effect with occupancy unchanged.
REQ-026 On entry to IDLE, the FIFO SHALL be flushed and dac_data SHALL be set to 12'h800.
REQ-027 No samples SHALL be popped in CONFIG; samples accepted in CONFIG SHALL wait for the first STREAM update.

Reset
REQ-028 While rst=1, all of the following SHALL hold: state IDLE, FIFO empty, frame_cnt 0, dac_data 12'h800, dac_set 0, dac_enable 0, s_ready 0, underrun 0.
REQ-029 Reset asserted mid-frame SHALL take effect immediately without waiting for a clock.
REQ-030 After rst deasserts, the first transition SHALL be taken only at a clk edge.

Configuration
REQ-031 With macro DAC_FEEDER_UNDERRUN_CNT_EN defined, the block SHALL add output underrun_cnt, 8 bits, which increments on each underrun pulse, saturates at 255, and clears on reset or entry to IDLE.
REQ-032 Without DAC_FEEDER_UNDERRUN_CNT_EN, port underrun_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset check: rst pulse mid-STREAM -> dac_data=12'h800, dac_enable=0, and s_ready=0 immediately.
REQ-034 Startup: run=1 -> dac_set=1 for exactly FRAME_LEN cycles, then 0; first pop occurs at frame_cnt=125 of the second frame (FRAME_LEN=128).
REQ-035 Conversion: samples 16'h0000, 16'h7FFF, 16'h8000, 16'hFFF7, 16'h7FF7 -> dac_data 12'h800, 12'hFFF, 12'h000, 12'h7FF, 12'hFFF respectively.
REQ-036 Backpressure: s_valid held high with no updates -> exactly 4 samples accepted, then s_ready=0; s_ready returns to 1 on the cycle after the next pop.
REQ-037 Underrun: FIFO empty at 3 consecutive updates -> dac_data held and 3 underrun pulses; with the macro defined, underrun_cnt=3.
REQ-038 Stop: run=0 with 2 samples queued -> next cycle IDLE, FIFO empty, and dac_data=12'h800.
